// File: rtl/core_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// core_pkg : shared opcode/aluop constants, overflow status codes, X/M FSM states
// Rev 1.0
// ------------------------------------------------------------------------
package core_pkg;

  localparam logic [4:0] c_op_rtype = 5'b00000;
  localparam logic [4:0] c_op_jal   = 5'b00011;
  localparam logic [4:0] c_op_addi  = 5'b00101;
  localparam logic [4:0] c_op_sw    = 5'b00111;
  localparam logic [4:0] c_op_lw    = 5'b01000;
  localparam logic [4:0] c_op_setx  = 5'b10101;

  localparam logic [4:0] c_alu_add  = 5'b00000;
  localparam logic [4:0] c_alu_sub  = 5'b00001;
  localparam logic [4:0] c_alu_mul  = 5'b00110;
  localparam logic [4:0] c_alu_div  = 5'b00111;

  localparam logic [2:0] c_st_add   = 3'd1;
  localparam logic [2:0] c_st_addi  = 3'd2;
  localparam logic [2:0] c_st_sub   = 3'd3;
  localparam logic [2:0] c_st_mul   = 3'd4;
  localparam logic [2:0] c_st_div   = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_WAIT = 2'd1,
    MD_DONE = 2'd2
  } xm_state_e;

  function automatic logic is_md_op(input logic [4:0] opcode, input logic [4:0] aluop);
    return (opcode == c_op_rtype) && ((aluop == c_alu_mul) || (aluop == c_alu_div));
  endfunction

endpackage
`default_nettype wire

// File: rtl/xm_stage_pipe_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// xm_stage_pipe_if : D/X inputs, multdiv handshake and X/M outputs of the stage
// Rev 1.0
// ------------------------------------------------------------------------
interface xm_stage_pipe_if #(
  parameter int DATA_W    = 32,
  parameter int OVF_CNT_W = 8
) ();

  logic              in_valid;
  logic [DATA_W-1:0] pc_dx;
  logic [DATA_W-1:0] read1_dx;
  logic [DATA_W-1:0] alu_dx;
  logic [DATA_W-1:0] target_dx;
  logic              alu_ovf;
  logic [31:0]       instr_dx;
  logic              md_ready;
  logic [DATA_W-1:0] md_result;
  logic              md_ovf;
  logic              stall_in;
  logic              flush;

  logic                 valid_xm;
  logic [DATA_W-1:0]    pc_xm;
  logic [DATA_W-1:0]    read1_xm;
  logic [DATA_W-1:0]    alu_xm;
  logic [DATA_W-1:0]    target_xm;
  logic [31:0]          instr_xm;
  logic [4:0]           opcode_xm;
  logic [4:0]           rd_xm;
  logic [4:0]           aluop_xm;
  logic                 rd_is_0;
  logic                 sw_xm;
  logic                 lw_xm;
  logic                 setx_xm;
  logic                 jal_xm;
  logic                 modifies_rd_xm;
  logic                 md_start;
  logic                 stall_dx;
  logic [OVF_CNT_W-1:0] ovf_count;

  modport master (
    output in_valid, pc_dx, read1_dx, alu_dx, target_dx, alu_ovf, instr_dx,
           md_ready, md_result, md_ovf, stall_in, flush,
    input  valid_xm, pc_xm, read1_xm, alu_xm, target_xm, instr_xm, opcode_xm,
           rd_xm, aluop_xm, rd_is_0, sw_xm, lw_xm, setx_xm, jal_xm,
           modifies_rd_xm, md_start, stall_dx, ovf_count
  );

  modport slave (
    input  in_valid, pc_dx, read1_dx, alu_dx, target_dx, alu_ovf, instr_dx,
           md_ready, md_result, md_ovf, stall_in, flush,
    output valid_xm, pc_xm, read1_xm, alu_xm, target_xm, instr_xm, opcode_xm,
           rd_xm, aluop_xm, rd_is_0, sw_xm, lw_xm, setx_xm, jal_xm,
           modifies_rd_xm, md_start, stall_dx, ovf_count
  );

endinterface
`default_nettype wire

// File: rtl/xm_ovf_override.sv
`default_nettype none
// ------------------------------------------------------------------------
// xm_ovf_override : picks the overflow status code and rewrites result/rd
// Rev 1.0
// ------------------------------------------------------------------------
module xm_ovf_override
  import core_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter int         STATUS_REG = 30,
  parameter logic [4:0] OVF_EN     = 5'b11111
) (
  input  logic [31:0]       i_instr,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_ovf,
  output logic [31:0]       o_instr,
  output logic [DATA_W-1:0] o_result,
  output logic              o_hit
);

  localparam logic [4:0] c_status_rd = 5'(STATUS_REG);

  logic [4:0] w_opcode;
  logic [4:0] w_aluop;
  logic [2:0] w_code;
  logic       w_en;

  assign w_opcode = i_instr[31:27];
  assign w_aluop  = i_instr[6:2];

  // addi carries immediate bits in the aluop field, so it is keyed on opcode alone
  always_comb begin
    w_code = 3'd0;
    w_en   = 1'b0;
    if (w_opcode == c_op_rtype) begin
      case (w_aluop)
        c_alu_add: begin w_code = c_st_add; w_en = OVF_EN[0]; end
        c_alu_sub: begin w_code = c_st_sub; w_en = OVF_EN[1]; end
        c_alu_mul: begin w_code = c_st_mul; w_en = OVF_EN[3]; end
        c_alu_div: begin w_code = c_st_div; w_en = OVF_EN[4]; end
        default:   begin w_code = 3'd0;     w_en = 1'b0;      end
      endcase
    end else if (w_opcode == c_op_addi) begin
      w_code = c_st_addi;
      w_en   = OVF_EN[2];
    end
  end

  assign o_hit    = i_ovf & w_en;
  assign o_result = o_hit ? DATA_W'(w_code) : i_result;
  assign o_instr  = o_hit ? {i_instr[31:27], c_status_rd, i_instr[21:0]} : i_instr;

endmodule
`default_nettype wire

// File: rtl/xm_stage_pipe.sv
`default_nettype none
// ------------------------------------------------------------------------
// xm_stage_pipe : X/M pipeline latch with multdiv wait FSM and overflow override
// Rev 1.0
// ------------------------------------------------------------------------
module xm_stage_pipe
  import core_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter int         STATUS_REG = 30,
  parameter int         OVF_CNT_W  = 8,
  parameter logic [4:0] OVF_EN     = 5'b11111
) (
  input  logic           rise,
  input  logic           reset,
  xm_stage_pipe_if.slave bus
);

  xm_state_e            r_state, w_state_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [DATA_W-1:0]    r_pc, r_read1, r_alu, r_target;
  logic [DATA_W-1:0]    w_pc_nxt, w_read1_nxt, w_alu_nxt, w_target_nxt;
  logic [31:0]          r_instr, w_instr_nxt;
  logic                 r_md_start, w_md_start_nxt;
  logic [OVF_CNT_W-1:0] r_ovf_count;

  logic [DATA_W-1:0]    r_h_pc, r_h_read1, r_h_target, r_h_result;
  logic [31:0]          r_h_instr;
  logic                 r_h_ovf;

  logic                 w_is_md, w_launch, w_capture;
  logic                 w_ld_dx, w_ld_hold, w_bubble, w_cnt_inc;
  logic [31:0]          w_dx_instr, w_hold_instr;
  logic [DATA_W-1:0]    w_dx_result, w_hold_result;
  logic                 w_dx_hit, w_hold_hit;

  assign w_is_md = is_md_op(bus.instr_dx[31:27], bus.instr_dx[6:2]);

  xm_ovf_override #(.DATA_W(DATA_W), .STATUS_REG(STATUS_REG), .OVF_EN(OVF_EN)) u_ovf_dx (
    .i_instr (bus.instr_dx),
    .i_result(bus.alu_dx),
    .i_ovf   (bus.alu_ovf),
    .o_instr (w_dx_instr),
    .o_result(w_dx_result),
    .o_hit   (w_dx_hit)
  );

  xm_ovf_override #(.DATA_W(DATA_W), .STATUS_REG(STATUS_REG), .OVF_EN(OVF_EN)) u_ovf_hold (
    .i_instr (r_h_instr),
    .i_result(r_h_result),
    .i_ovf   (r_h_ovf),
    .o_instr (w_hold_instr),
    .o_result(w_hold_result),
    .o_hit   (w_hold_hit)
  );

  // Flush outranks stall and every FSM transition; md_ready only matters in MD_WAIT
  always_comb begin
    w_state_nxt    = r_state;
    w_md_start_nxt = 1'b0;
    w_launch       = 1'b0;
    w_capture      = 1'b0;
    w_ld_dx        = 1'b0;
    w_ld_hold      = 1'b0;
    w_bubble       = 1'b0;
    if (bus.flush) begin
      w_bubble    = 1'b1;
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.stall_in) begin
            if (bus.in_valid && !w_is_md) begin
              w_ld_dx = 1'b1;
            end else begin
              w_bubble = 1'b1;
              if (bus.in_valid) begin
                w_launch       = 1'b1;
                w_md_start_nxt = 1'b1;
                w_state_nxt    = MD_WAIT;
              end
            end
          end
        end
        MD_WAIT: begin
          w_bubble = 1'b1;
          if (bus.md_ready) begin
            w_capture   = 1'b1;
            w_state_nxt = MD_DONE;
          end
        end
        MD_DONE: begin
          if (!bus.stall_in) begin
            w_ld_hold   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_bubble    = 1'b1;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_valid_nxt  = r_valid;
    w_pc_nxt     = r_pc;
    w_read1_nxt  = r_read1;
    w_alu_nxt    = r_alu;
    w_target_nxt = r_target;
    w_instr_nxt  = r_instr;
    w_cnt_inc    = 1'b0;
    if (w_bubble) begin
      w_valid_nxt  = 1'b0;
      w_pc_nxt     = '0;
      w_read1_nxt  = '0;
      w_alu_nxt    = '0;
      w_target_nxt = '0;
      w_instr_nxt  = '0;
    end else if (w_ld_dx) begin
      w_valid_nxt  = 1'b1;
      w_pc_nxt     = bus.pc_dx;
      w_read1_nxt  = bus.read1_dx;
      w_alu_nxt    = w_dx_result;
      w_target_nxt = bus.target_dx;
      w_instr_nxt  = w_dx_instr;
      w_cnt_inc    = w_dx_hit;
    end else if (w_ld_hold) begin
      w_valid_nxt  = 1'b1;
      w_pc_nxt     = r_h_pc;
      w_read1_nxt  = r_h_read1;
      w_alu_nxt    = w_hold_result;
      w_target_nxt = r_h_target;
      w_instr_nxt  = w_hold_instr;
      w_cnt_inc    = w_hold_hit;
    end
  end

  always_ff @(posedge rise or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_read1     <= '0;
      r_alu       <= '0;
      r_target    <= '0;
      r_instr     <= '0;
      r_md_start  <= 1'b0;
      r_ovf_count <= '0;
      r_h_pc      <= '0;
      r_h_read1   <= '0;
      r_h_target  <= '0;
      r_h_instr   <= '0;
      r_h_result  <= '0;
      r_h_ovf     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_valid    <= w_valid_nxt;
      r_pc       <= w_pc_nxt;
      r_read1    <= w_read1_nxt;
      r_alu      <= w_alu_nxt;
      r_target   <= w_target_nxt;
      r_instr    <= w_instr_nxt;
      r_md_start <= w_md_start_nxt;
      if (w_cnt_inc && (r_ovf_count != '1)) begin
        r_ovf_count <= r_ovf_count + OVF_CNT_W'(1);
      end
      if (w_launch) begin
        r_h_pc     <= bus.pc_dx;
        r_h_read1  <= bus.read1_dx;
        r_h_target <= bus.target_dx;
        r_h_instr  <= bus.instr_dx;
      end
      if (w_capture) begin
        r_h_result <= bus.md_result;
        r_h_ovf    <= bus.md_ovf;
      end
    end
  end

  assign bus.valid_xm       = r_valid;
  assign bus.pc_xm          = r_pc;
  assign bus.read1_xm       = r_read1;
  assign bus.alu_xm         = r_alu;
  assign bus.target_xm      = r_target;
  assign bus.instr_xm       = r_instr;
  assign bus.opcode_xm      = r_instr[31:27];
  assign bus.rd_xm          = r_instr[26:22];
  assign bus.aluop_xm       = r_instr[6:2];
  assign bus.rd_is_0        = r_valid & (r_instr[26:22] == 5'd0);
  assign bus.sw_xm          = r_valid & (r_instr[31:27] == c_op_sw);
  assign bus.lw_xm          = r_valid & (r_instr[31:27] == c_op_lw);
  assign bus.setx_xm        = r_valid & (r_instr[31:27] == c_op_setx);
  assign bus.jal_xm         = r_valid & (r_instr[31:27] == c_op_jal);
  assign bus.modifies_rd_xm = r_valid & ((r_instr[31:27] == c_op_lw)   |
                                         (r_instr[31:27] == c_op_rtype) |
                                         (r_instr[31:27] == c_op_addi)  |
                                         (r_instr[31:27] == c_op_setx));
  assign bus.md_start       = r_md_start;
  assign bus.stall_dx       = bus.stall_in | (r_state != IDLE);
  assign bus.ovf_count      = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_xm_stage_pipe.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_xm_stage_pipe : directed scoreboard bench for the X/M pipeline latch
// Rev 1.0
// ------------------------------------------------------------------------
module tb_xm_stage_pipe;

  logic rise = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   md_pulses;
  int   stall_cycles;
  logic stall_at_edge = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] instr;
    logic        mod;
    logic [3:0]  dec;   // {sw, lw, setx, jal}
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  xm_stage_pipe_if #(.DATA_W(32), .OVF_CNT_W(8)) bus ();

  xm_stage_pipe #(
    .DATA_W(32), .STATUS_REG(30), .OVF_CNT_W(8), .OVF_EN(5'b11111)
  ) dut (
    .rise (rise),
    .reset(reset),
    .bus  (bus)
  );

  always #5 rise = ~rise;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] aluop);
    return {5'b00000, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd, input logic [16:0] imm);
    return {op, rd, 5'd1, imm};
  endfunction

  function automatic logic [31:0] with_rd(input logic [31:0] ins, input logic [4:0] rd);
    return {ins[31:27], rd, ins[21:0]};
  endfunction

  task automatic tick();
    @(posedge rise);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] alu, input logic ovf);
    bus.in_valid  = 1'b1;
    bus.instr_dx  = instr;
    bus.pc_dx     = pc;
    bus.alu_dx    = alu;
    bus.read1_dx  = pc ^ 32'h0000_5a5a;
    bus.target_dx = pc + 32'd4;
    bus.alu_ovf   = ovf;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] instr,
                      input logic mod, input logic [3:0] dec);
    exp_t e;
    e.pc = pc; e.alu = alu; e.instr = instr; e.mod = mod; e.dec = dec;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // A new X/M entry appears after any edge that was not stalled
  always @(posedge rise) stall_at_edge = bus.stall_in;

  always @(negedge rise) begin
    if (!reset && bus.valid_xm && !stall_at_edge) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'(bus.valid_xm), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("pc_xm",     64'(bus.pc_xm),     64'(mon_e.pc));
        chk("read1_xm",  64'(bus.read1_xm),  64'(mon_e.pc ^ 32'h0000_5a5a));
        chk("target_xm", 64'(bus.target_xm), 64'(mon_e.pc + 32'd4));
        chk("alu_xm",    64'(bus.alu_xm),    64'(mon_e.alu));
        chk("instr_xm",  64'(bus.instr_xm),  64'(mon_e.instr));
        chk("rd_xm",     64'(bus.rd_xm),     64'(mon_e.instr[26:22]));
        chk("rd_is_0",   64'(bus.rd_is_0),   64'(mon_e.instr[26:22] == 5'd0));
        chk("modifies",  64'(bus.modifies_rd_xm), 64'(mon_e.mod));
        chk("decodes",   64'({bus.sw_xm, bus.lw_xm, bus.setx_xm, bus.jal_xm}), 64'(mon_e.dec));
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.pc_dx     = '0;
    bus.read1_dx  = '0;
    bus.alu_dx    = '0;
    bus.target_dx = '0;
    bus.alu_ovf   = 1'b0;
    bus.instr_dx  = '0;
    bus.md_ready  = 1'b0;
    bus.md_result = '0;
    bus.md_ovf    = 1'b0;
    bus.stall_in  = 1'b0;
    bus.flush     = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(bus.valid_xm), 64'd0);
    chk("rst_alu",   64'(bus.alu_xm),   64'd0);
    chk("rst_instr", 64'(bus.instr_xm), 64'd0);
    chk("rst_pc",    64'(bus.pc_xm),    64'd0);
    chk("rst_mdst",  64'(bus.md_start), 64'd0);
    chk("rst_cnt",   64'(bus.ovf_count), 64'd0);
    chk("rst_stall", 64'(bus.stall_dx), 64'd0);
    reset = 1'b0;
    tick();

    // Plain and overflowing single-cycle instructions back to back
    drive(rtype(5'd3, 5'b00000), 32'h100, 32'd7, 1'b0);
    push(32'h100, 32'd7, rtype(5'd3, 5'b00000), 1'b1, 4'b0000);
    tick();
    drive(rtype(5'd4, 5'b00001), 32'h104, 32'h1234, 1'b1);
    push(32'h104, 32'd3, with_rd(rtype(5'd4, 5'b00001), 5'd30), 1'b1, 4'b0000);
    tick();
    drive(itype(5'b00101, 5'd6, 17'h10), 32'h108, 32'h55, 1'b1);
    push(32'h108, 32'd2, with_rd(itype(5'b00101, 5'd6, 17'h10), 5'd30), 1'b1, 4'b0000);
    tick();
    drive(itype(5'b01000, 5'd0, 17'h20), 32'h10c, 32'h900, 1'b0);
    push(32'h10c, 32'h900, itype(5'b01000, 5'd0, 17'h20), 1'b1, 4'b0100);
    tick();
    drive(itype(5'b00111, 5'd9, 17'h4), 32'h110, 32'h904, 1'b1);
    push(32'h110, 32'h904, itype(5'b00111, 5'd9, 17'h4), 1'b0, 4'b1000);
    tick();
    drive(rtype(5'd11, 5'b00010), 32'h114, 32'hff, 1'b1);
    push(32'h114, 32'hff, rtype(5'd11, 5'b00010), 1'b1, 4'b0000);
    tick();
    drive(itype(5'b00011, 5'd0, 17'h40), 32'h118, 32'h11c, 1'b0);
    push(32'h118, 32'h11c, itype(5'b00011, 5'd0, 17'h40), 1'b0, 4'b0001);
    tick();
    drive(itype(5'b10101, 5'd30, 17'h3), 32'h11c, 32'h3, 1'b0);
    push(32'h11c, 32'h3, itype(5'b10101, 5'd30, 17'h3), 1'b1, 4'b0010);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("cnt_after_alu", 64'(bus.ovf_count), 64'd2);

    // Downstream stall holds the current X/M contents
    drive(rtype(5'd7, 5'b00000), 32'h200, 32'h77, 1'b0);
    push(32'h200, 32'h77, rtype(5'd7, 5'b00000), 1'b1, 4'b0000);
    tick();
    drive(rtype(5'd8, 5'b00000), 32'h204, 32'h88, 1'b0);
    push(32'h204, 32'h88, rtype(5'd8, 5'b00000), 1'b1, 4'b0000);
    bus.stall_in = 1'b1;
    tick();
    chk("stall_hold_alu1", 64'(bus.alu_xm), 64'h77);
    chk("stall_dx_on", 64'(bus.stall_dx), 64'd1);
    tick();
    chk("stall_hold_alu2", 64'(bus.alu_xm), 64'h77);
    bus.stall_in = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();

    // mul: result four cycles after launch
    md_pulses    = 0;
    stall_cycles = 0;
    drive(rtype(5'd5, 5'b00110), 32'h300, 32'hdead, 1'b0);
    push(32'h300, 32'h40, rtype(5'd5, 5'b00110), 1'b1, 4'b0000);
    tick();
    bus.in_valid = 1'b0;
    chk("mul_start", 64'(bus.md_start), 64'd1);
    chk("mul_bubble_valid", 64'(bus.valid_xm), 64'd0);
    chk("mul_bubble_instr", 64'(bus.instr_xm), 64'd0);
    md_pulses    += int'(bus.md_start);
    stall_cycles += int'(bus.stall_dx);
    for (int i = 0; i < 3; i++) begin
      tick();
      md_pulses    += int'(bus.md_start);
      stall_cycles += int'(bus.stall_dx);
    end
    bus.md_ready  = 1'b1;
    bus.md_result = 32'h40;
    bus.md_ovf    = 1'b0;
    tick();
    bus.md_ready  = 1'b0;
    bus.md_result = 32'h1111;
    md_pulses    += int'(bus.md_start);
    stall_cycles += int'(bus.stall_dx);
    chk("mul_wait_valid", 64'(bus.valid_xm), 64'd0);
    tick();
    md_pulses += int'(bus.md_start);
    chk("mul_done_valid", 64'(bus.valid_xm), 64'd1);
    chk("mul_release", 64'(bus.stall_dx), 64'd0);
    chk("mul_pulses", 64'(md_pulses), 64'd1);
    chk("mul_stall_cycles", 64'(stall_cycles), 64'd5);
    tick();

    // div overflow held in MD_DONE by a downstream stall
    drive(rtype(5'd8, 5'b00111), 32'h400, 32'h0, 1'b0);
    push(32'h400, 32'd5, with_rd(rtype(5'd8, 5'b00111), 5'd30), 1'b1, 4'b0000);
    tick();
    bus.in_valid  = 1'b0;
    bus.md_ready  = 1'b1;
    bus.md_result = 32'h77;
    bus.md_ovf    = 1'b1;
    tick();
    bus.md_ready = 1'b0;
    bus.md_ovf   = 1'b0;
    bus.stall_in = 1'b1;
    tick();
    chk("div_hold1_valid", 64'(bus.valid_xm), 64'd0);
    chk("div_hold_stall", 64'(bus.stall_dx), 64'd1);
    tick();
    chk("div_hold2_valid", 64'(bus.valid_xm), 64'd0);
    bus.stall_in = 1'b0;
    tick();
    chk("div_cnt", 64'(bus.ovf_count), 64'd3);
    tick();

    // Flush during MD_WAIT; the late md_ready must be ignored
    drive(rtype(5'd9, 5'b00110), 32'h500, 32'h0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_idle", 64'(bus.stall_dx), 64'd0);
    chk("flush_valid", 64'(bus.valid_xm), 64'd0);
    bus.md_ready  = 1'b1;
    bus.md_result = 32'h99;
    tick();
    bus.md_ready = 1'b0;
    chk("late_ready_valid", 64'(bus.valid_xm), 64'd0);
    chk("late_ready_stall", 64'(bus.stall_dx), 64'd0);
    drive(rtype(5'd10, 5'b00000), 32'h504, 32'h1, 1'b0);
    push(32'h504, 32'h1, rtype(5'd10, 5'b00000), 1'b1, 4'b0000);
    tick();
    bus.in_valid = 1'b0;
    tick();

    // Flush beats a new multdiv launch in the same cycle
    drive(rtype(5'd11, 5'b00110), 32'h508, 32'h0, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_md_start", 64'(bus.md_start), 64'd0);
    chk("flush_md_state", 64'(bus.stall_dx), 64'd0);
    tick();

    // Flush beats a downstream stall on a valid entry
    drive(rtype(5'd12, 5'b00000), 32'h600, 32'h66, 1'b0);
    push(32'h600, 32'h66, rtype(5'd12, 5'b00000), 1'b1, 4'b0000);
    tick();
    bus.in_valid = 1'b0;
    bus.stall_in = 1'b1;
    bus.flush    = 1'b1;
    tick();
    chk("flush_stall_valid", 64'(bus.valid_xm), 64'd0);
    bus.stall_in = 1'b0;
    bus.flush    = 1'b0;
    tick();

    // 300 overflowing adds: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      drive(rtype(5'd12, 5'b00000), 32'h1000 + 32'(i * 4), 32'(i), 1'b1);
      push(32'h1000 + 32'(i * 4), 32'd1, with_rd(rtype(5'd12, 5'b00000), 5'd30), 1'b1, 4'b0000);
      tick();
      if (i == 250) chk("cnt_254", 64'(bus.ovf_count), 64'd254);
      if (i == 251) chk("cnt_255", 64'(bus.ovf_count), 64'd255);
    end
    bus.in_valid = 1'b0;
    chk("cnt_saturated", 64'(bus.ovf_count), 64'd255);
    drain(10);

    // Asynchronous reset mid-stream clears outputs before the next edge
    drive(rtype(5'd13, 5'b00000), 32'h2000, 32'h42, 1'b0);
    push(32'h2000, 32'h42, rtype(5'd13, 5'b00000), 1'b1, 4'b0000);
    tick();
    #5;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.valid_xm), 64'd0);
    chk("arst_alu",   64'(bus.alu_xm),   64'd0);
    chk("arst_instr", 64'(bus.instr_xm), 64'd0);
    chk("arst_cnt",   64'(bus.ovf_count), 64'd0);
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Asynchronous reset aborts a multdiv wait
    drive(rtype(5'd14, 5'b00111), 32'h3000, 32'h0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("arst_md_wait", 64'(bus.stall_dx), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_md_idle", 64'(bus.stall_dx), 64'd0);
    chk("arst_md_start", 64'(bus.md_start), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_valid", 64'(bus.valid_xm), 64'd0);
    drain(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xm_stage_pipe.md
Name: xm_stage_pipe

Overview:
- Parametrised next-generation execute/memory pipeline latch for the 5-stage core.
- Captures PC, operand, ALU/multdiv result, instruction and jump target from D/X into X/M. Adds a valid bit, synchronous flush and downstream stall.
- Replaces the result and destination register with a status code and STATUS_REG on arithmetic overflow, with per-code enables.
- Owns a multdiv wait FSM that holds the pipe until the multi-cycle unit finishes, and keeps a saturating overflow counter.

Parameters:
- DATA_W, 32, width of PC, read1, ALU result, multdiv result and target.
- STATUS_REG, 30, register index written on overflow (5-bit value).
- OVF_CNT_W, 8, width of the saturating overflow counter.
- OVF_EN, 5'b11111, per-code override enable; bit order {div, mul, addi, sub, add}.

Ports:
- rise  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  D/X holds a real instruction.
- pc_dx, read1_dx, alu_dx, target_dx  in  DATA_W each  D/X payload.
- alu_ovf  in  1  ALU overflow for the instruction in D/X.
- instr_dx  in  32  D/X instruction word.
- md_ready  in  1  multdiv result valid; one-cycle pulse.
- md_result  in  DATA_W  multdiv result.
- md_ovf  in  1  multdiv overflow, qualified by md_ready.
- stall_in  in  1  M/W cannot accept this cycle.
- flush  in  1  kill the stage contents (branch/jump redirect).
- valid_xm  out  1  X/M holds a real instruction.
- pc_xm, read1_xm, alu_xm, target_xm  out  DATA_W each  X/M payload.
- instr_xm  out  32  X/M instruction; rd field overridden on overflow.
- opcode_xm, rd_xm, aluop_xm  out  5 each  instr_xm[31:27], [26:22], [6:2].
- rd_is_0, sw_xm, lw_xm, setx_xm, jal_xm, modifies_rd_xm  out  1 each  decodes of instr_xm, all gated by valid_xm.
- md_start  out  1  pulse launching the multdiv unit.
- stall_dx  out  1  hold D/X and earlier stages.
- ovf_count  out  OVF_CNT_W  committed-overflow count.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - all payload outputs and instr_xm to 0;
  - valid_xm=0, state=IDLE, ovf_count=0, md_start=0.
- Instruction classes:
  - is_md = instr_dx opcode 00000 with aluop 00110 (mul) or 00111 (div).
  - Opcodes: sw 00111, lw 01000, setx 10101, jal 00011, addi 00101.
  - modifies_rd_xm = lw | R-type | addi | setx.
- stall_dx = stall_in | (state != IDLE); purely combinational.
- FSM, state IDLE:
  - stall_in=1: hold all registers.
  - in_valid=1 and !is_md: load payload; valid_xm=1; latency 1 cycle.
  - in_valid=1 and is_md: latch pc/read1/instr/target into hold registers; pulse md_start for 1 cycle; load a bubble into X/M (valid_xm=0, instr_xm=0); go to MD_WAIT.
  - in_valid=0: load a bubble.
- FSM, state MD_WAIT:
  - Loads bubbles into X/M.
  - md_ready=1: capture md_result and md_ovf into the hold registers; go to MD_DONE.
- FSM, state MD_DONE:
  - stall_in=0: load X/M from the hold registers; valid_xm=1; go to IDLE.
  - stall_in=1: remain in MD_DONE.
- Overflow override, applied when loading X/M:
  - ovf = alu_ovf (normal path) or held md_ovf (MD_DONE path), AND-ed with the OVF_EN bit for the code.
  - Codes: add 1, sub 3, addi 2, mul 4, div 5, zero-extended to DATA_W.
  - Any other aluop yields no override.
  - When ovf=1: alu_xm = code and instr_xm[26:22] = STATUS_REG; all other fields pass unchanged.
- ovf_count increments once per overridden instruction when it loads with valid_xm=1. It saturates at all-ones with no wrap.
- Flush (synchronous) has priority over stall_in and all FSM transitions:
  - loads a bubble; state goes to IDLE;
  - an outstanding multdiv result is ignored, because md_ready is ignored in IDLE.
  - flush and a new md instruction in the same cycle: flush wins and md_start stays 0.
- Asynchronous reset during MD_WAIT aborts the operation; the environment also resets the multdiv unit.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants (R-type, addi, sw, lw, jal, setx);
  - aluop constants (add, sub, mul, div);
  - overflow status codes 1..5;
  - FSM state encoding {IDLE, MD_WAIT, MD_DONE}.
- One sub-module, xm_ovf_override: combinational code select plus rd replacement, reused by the D/X-path and hold-path loads.

Test Plan:
- add, alu_dx=7, alu_ovf=0, rd=3 -> next edge: valid_xm=1, alu_xm=7, rd_xm=3, modifies_rd_xm=1.
- sub with alu_ovf=1 -> alu_xm=3, rd_xm=30, ovf_count=1; addi with overflow -> alu_xm=2.
- mul accepted, md_ready 4 cycles later with md_result=0x40, stall_in=0 -> md_start pulses once; stall_dx high for 5 cycles; valid_xm=1 with alu_xm=0x40 on the 6th edge.
- div with md_ovf=1 and stall_in=1 for 2 cycles in MD_DONE -> holds; then alu_xm=5, rd_xm=30.
- flush asserted in MD_WAIT -> bubble, state IDLE; a late md_ready is ignored; the next add proceeds normally.
- 300 overflows with OVF_CNT_W=8 -> ovf_count saturates at 255. Asynchronous reset mid-stream -> all outputs 0 immediately, before the next edge.
